// File: rtl/keypad_time_pkg.sv
// Shared types, constants and key-decode helpers for the keypad time-entry block.
// Combinational helpers only; no state lives here.
package keypad_time_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    DONE  = 3'd2,
    ERROR = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int         BCD_W       = 4;
  localparam logic [3:0] MAX_TEN_SEC = 4'd5;

  // Six-digit-wide defaults; the top slices them down to its own digit count.
  localparam logic [23:0] DEF_PRESET1 = 24'h000005;
  localparam logic [23:0] DEF_PRESET2 = 24'h000030;
  localparam logic [23:0] DEF_PRESET3 = 24'h000100;

  function automatic logic is_onehot10(input logic [9:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

  function automatic logic [3:0] encode10(input logic [9:0] v);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) if (v[i]) d = 4'(i);
    return d;
  endfunction

endpackage

// File: rtl/keypad_time_entry_if.sv
// Keypad-side levels in, time/handshake results out; master drives keys, slave is the block.
interface keypad_time_entry_if #(
  parameter int NUM_DIGITS = 3
) ();
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic                    en;
  logic                    mode;
  logic                    sharp;
  logic                    star;
  logic [9:0]              keypad;
  logic [4*NUM_DIGITS-1:0] time_bcd;
  logic [CW-1:0]           digit_count;
  logic                    completeSetting;
  logic                    entry_error;
  logic                    setting_valid;

  modport master (
    output en, mode, sharp, star, keypad,
    input  time_bcd, digit_count, completeSetting, entry_error, setting_valid
  );

  modport slave (
    input  en, mode, sharp, star, keypad,
    output time_bcd, digit_count, completeSetting, entry_error, setting_valid
  );
endinterface

// File: rtl/keypad_time_entry_event_detect.sv
// Press-edge detection for digit/#/* keys with enable gating and star > sharp > digit priority.
// Events are combinational from current levels against one-cycle-old registered levels.
module keypad_event_detect
  import keypad_time_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       sharp,
  input  logic       star,
  input  logic [9:0] keypad,
  output logic       digit_ev,
  output logic [3:0] digit,
  output logic       sharp_ev,
  output logic       star_ev
);

  logic [9:0] keypad_q;
  logic       sharp_q;
  logic       star_q;

  // History tracks levels even while disabled, so a key held across en rising never fires.
  always_ff @(posedge clock) begin
    if (!reset) begin
      keypad_q <= '0;
      sharp_q  <= 1'b0;
      star_q   <= 1'b0;
    end else begin
      keypad_q <= keypad;
      sharp_q  <= sharp;
      star_q   <= star;
    end
  end

  logic raw_digit, raw_sharp, raw_star;

  always_comb begin
    raw_star  = en & star & ~star_q;
    raw_sharp = en & sharp & ~sharp_q;
    raw_digit = en & is_onehot10(keypad) & (keypad_q == 10'd0);
    star_ev   = raw_star;
    sharp_ev  = raw_sharp & ~raw_star;
    digit_ev  = raw_digit & ~raw_sharp & ~raw_star;
    digit     = encode10(keypad);
  end

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad time entry: BCD shift-in or preset keys, validated on # and held for the countdown.
// Outputs registered; edits visible one cycle after the key edge, confirm pulse likewise.
module keypad_time_entry
  import keypad_time_pkg::*;
#(
  parameter int                      NUM_DIGITS = 3,
  parameter logic [4*NUM_DIGITS-1:0] PRESET1    = DEF_PRESET1[4*NUM_DIGITS-1:0],
  parameter logic [4*NUM_DIGITS-1:0] PRESET2    = DEF_PRESET2[4*NUM_DIGITS-1:0],
  parameter logic [4*NUM_DIGITS-1:0] PRESET3    = DEF_PRESET3[4*NUM_DIGITS-1:0]
) (
  input  logic                  clock,
  input  logic                  reset,
  keypad_time_entry_if.slave    bus
);

  localparam int            W    = BCD_W * NUM_DIGITS;
  localparam int            CW   = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);

  state_t        state;
  logic [W-1:0]  time_q;
  logic [CW-1:0] count_q;
  logic          complete_q, error_q, valid_q;

  logic       digit_ev, sharp_ev, star_ev;
  logic [3:0] digit;

  keypad_event_detect u_event (
    .clock    (clock),
    .reset    (reset),
    .en       (bus.en),
    .sharp    (bus.sharp),
    .star     (bus.star),
    .keypad   (bus.keypad),
    .digit_ev (digit_ev),
    .digit    (digit),
    .sharp_ev (sharp_ev),
    .star_ev  (star_ev)
  );

  logic [W-1:0]  base_time, edit_time;
  logic [CW-1:0] base_cnt, edit_cnt;
  logic          confirm_ok;

  // A digit pressed while holding a confirmed time starts a fresh entry from zero.
  always_comb begin
    base_time = (state == HOLD) ? '0 : time_q;
    base_cnt  = (state == HOLD) ? '0 : count_q;
    edit_time = base_time;
    edit_cnt  = base_cnt;
    if (bus.mode) begin
      if (base_cnt < FULL) begin
        edit_time = {base_time[W-5:0], digit};
        edit_cnt  = base_cnt + 1'b1;
      end
    end else begin
      case (digit)
        4'd1:    begin edit_time = PRESET1; edit_cnt = FULL; end
        4'd2:    begin edit_time = PRESET2; edit_cnt = FULL; end
        4'd3:    begin edit_time = PRESET3; edit_cnt = FULL; end
        default: ;
      endcase
    end
    confirm_ok = (time_q != '0) && (time_q[7:4] <= MAX_TEN_SEC);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      time_q     <= '0;
      count_q    <= '0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else if (bus.en) begin
      complete_q <= 1'b0;
      error_q    <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (star_ev) begin
            time_q  <= '0;
            count_q <= '0;
            state   <= IDLE;
          end else if (sharp_ev) begin
            if (state == ENTRY && confirm_ok) begin
              complete_q <= 1'b1;
              valid_q    <= 1'b1;
              state      <= DONE;
            end else begin
              error_q <= 1'b1;
              time_q  <= '0;
              count_q <= '0;
              state   <= ERROR;
            end
          end else if (digit_ev) begin
            time_q  <= edit_time;
            count_q <= edit_cnt;
            state   <= ENTRY;
          end
        end
        DONE:  state <= HOLD;
        ERROR: state <= IDLE;
        HOLD: begin
          if (star_ev) begin
            time_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            state   <= IDLE;
          end else if (digit_ev) begin
            time_q  <= edit_time;
            count_q <= edit_cnt;
            valid_q <= 1'b0;
            state   <= ENTRY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.time_bcd        = time_q;
  assign bus.digit_count     = count_q;
  assign bus.completeSetting = complete_q;
  assign bus.entry_error     = error_q;
  assign bus.setting_valid   = valid_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Bench for keypad_time_entry: directed per-cycle vector table, then random keys against a digit-list model.
module tb_keypad_time_entry;

  localparam int N  = 3;
  localparam int W  = 4 * N;
  localparam int CW = $clog2(N + 1);

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  keypad_time_entry_if #(.NUM_DIGITS(N)) bus ();

  keypad_time_entry #(.NUM_DIGITS(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst, en, mode, sh, st;
    logic [9:0]   key;
    logic [W-1:0] t;
    int           cnt;
    logic         cs, er, v;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, en, mode, sh, st, input logic [9:0] key,
                     input logic [W-1:0] t, input int cnt, input logic cs, er, v);
    vec_t r;
    r.rst = rst; r.en = en; r.mode = mode; r.sh = sh; r.st = st; r.key = key;
    r.t = t; r.cnt = cnt; r.cs = cs; r.er = er; r.v = v;
    vecs.push_back(r);
  endtask

  function automatic logic [9:0] k(input int d);
    return 10'b1 << d;
  endfunction

  task automatic compare(input string name, input logic [W-1:0] et, input int ec,
                         input logic ecs, input logic eer, input logic ev);
    checks++;
    if (bus.time_bcd !== et || bus.digit_count !== CW'(ec) || bus.completeSetting !== ecs ||
        bus.entry_error !== eer || bus.setting_valid !== ev) begin
      errors++;
      $display("FAIL %s: got time=%h cnt=%0d cs=%b err=%b valid=%b, want time=%h cnt=%0d cs=%b err=%b valid=%b",
               name, bus.time_bcd, bus.digit_count, bus.completeSetting, bus.entry_error,
               bus.setting_valid, et, ec, ecs, eer, ev);
    end
  endtask

  // Reference model: the entry is a list of digits (oldest first) plus a few flags.
  int         digits[$];
  bit         held, m_valid, m_cs, m_er;
  int         lock;
  logic [9:0] pk;
  logic       ps, pst;

  function automatic logic [W-1:0] m_time();
    logic [W-1:0] t;
    t = '0;
    foreach (digits[i]) t = (t << 4) | W'(digits[i]);
    return t;
  endfunction

  task automatic model_step();
    bit st_e, sh_e, dig_e;
    int d;
    logic [W-1:0] t, p;
    if (!reset) begin
      digits.delete(); held = 0; m_valid = 0; m_cs = 0; m_er = 0; lock = 0;
      pk = '0; ps = 0; pst = 0;
    end else begin
      st_e  = bus.en && bus.star && !pst;
      sh_e  = bus.en && bus.sharp && !ps;
      dig_e = bus.en && ($countones(bus.keypad) == 1) && (pk == '0);
      d = 0;
      for (int i = 0; i < 10; i++) if (bus.keypad[i]) d = i;
      if (bus.en) begin
        m_cs = 0; m_er = 0;
        if (lock != 0) begin
          lock = 0;
        end else if (st_e) begin
          digits.delete(); held = 0; m_valid = 0;
        end else if (sh_e) begin
          if (!held) begin
            t = m_time();
            if (t != '0 && t[7:4] <= 4'd5) begin
              m_cs = 1; m_valid = 1; held = 1;
            end else begin
              m_er = 1; digits.delete();
            end
            lock = 1;
          end
        end else if (dig_e) begin
          if (held) begin
            digits.delete(); held = 0; m_valid = 0;
          end
          if (bus.mode) begin
            if (digits.size() < N) digits.push_back(d);
          end else if (d >= 1 && d <= 3) begin
            p = (d == 1) ? W'(12'h005) : (d == 2) ? W'(12'h030) : W'(12'h100);
            digits.delete();
            for (int i = N - 1; i >= 0; i--) digits.push_back(int'(p[4*i +: 4]));
          end
        end
      end
      pk = bus.keypad; ps = bus.sharp; pst = bus.star;
    end
  endtask

  logic [9:0] rkey;
  int         r;

  initial begin
    bus.en = 1'b0; bus.mode = 1'b1; bus.sharp = 1'b0; bus.star = 1'b0; bus.keypad = '0;

    //   rst en md sh st key        time      cnt cs er v
    add(0, 0, 1, 0, 0, 10'd0,  12'h000, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 10'd0,  12'h000, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, k(5),   12'h005, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h005, 1, 0, 0, 0);
    add(1, 1, 1, 0, 1, 10'd0,  12'h000, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h000, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, k(1),   12'h001, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h001, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, k(3),   12'h013, 2, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h013, 2, 0, 0, 0);
    add(1, 1, 1, 0, 0, k(0),   12'h130, 3, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h130, 3, 0, 0, 0);
    add(1, 1, 1, 0, 0, k(8),   12'h130, 3, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h130, 3, 0, 0, 0);
    add(1, 1, 1, 1, 0, 10'd0,  12'h130, 3, 1, 0, 1);
    add(1, 1, 1, 1, 0, 10'd0,  12'h130, 3, 0, 0, 1);
    add(1, 1, 1, 0, 0, 10'd0,  12'h130, 3, 0, 0, 1);
    add(1, 1, 1, 1, 0, 10'd0,  12'h130, 3, 0, 0, 1);
    add(1, 1, 1, 0, 0, k(1),   12'h001, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h001, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, k(7),   12'h017, 2, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h017, 2, 0, 0, 0);
    add(1, 1, 1, 0, 0, k(5),   12'h175, 3, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h175, 3, 0, 0, 0);
    add(1, 1, 1, 1, 0, 10'd0,  12'h000, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h000, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, k(2),   12'h030, 3, 0, 0, 0);
    add(1, 1, 0, 0, 0, 10'd0,  12'h030, 3, 0, 0, 0);
    add(1, 1, 0, 0, 0, k(7),   12'h030, 3, 0, 0, 0);
    add(1, 1, 0, 0, 0, 10'd0,  12'h030, 3, 0, 0, 0);
    add(1, 1, 0, 1, 0, 10'd0,  12'h030, 3, 1, 0, 1);
    add(1, 1, 0, 0, 0, 10'd0,  12'h030, 3, 0, 0, 1);
    add(1, 1, 0, 0, 0, k(3),   12'h100, 3, 0, 0, 0);
    add(1, 1, 0, 0, 0, 10'd0,  12'h100, 3, 0, 0, 0);
    add(1, 1, 0, 1, 1, 10'd0,  12'h000, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 10'd0,  12'h000, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, k(4) | k(6), 12'h000, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h000, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, k(4),   12'h000, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, k(4),   12'h000, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h000, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 10'd0,  12'h000, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h000, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, k(3),   12'h100, 3, 0, 0, 0);
    add(1, 1, 0, 0, 0, 10'd0,  12'h100, 3, 0, 0, 0);
    add(1, 1, 0, 1, 0, 10'd0,  12'h100, 3, 1, 0, 1);
    add(1, 1, 0, 0, 0, 10'd0,  12'h100, 3, 0, 0, 1);
    add(1, 1, 1, 0, 0, k(9),   12'h009, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h009, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, k(1),   12'h091, 2, 0, 0, 0);
    add(0, 1, 1, 0, 0, 10'd0,  12'h000, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10'd0,  12'h000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; bus.en = vecs[i].en; bus.mode = vecs[i].mode;
      bus.sharp = vecs[i].sh; bus.star = vecs[i].st; bus.keypad = vecs[i].key;
      @(posedge clock);
      #1;
      compare($sformatf("vec%0d", i), vecs[i].t, vecs[i].cnt, vecs[i].cs, vecs[i].er, vecs[i].v);
    end

    // Random phase: start from a clean reset so model and design agree.
    reset = 1'b0; bus.keypad = '0; bus.sharp = 1'b0; bus.star = 1'b0;
    model_step();
    @(posedge clock);
    #1;
    compare("rand_reset", m_time(), digits.size(), m_cs, m_er, m_valid);
    rkey = '0;
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 299) != 0);
      bus.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, 9);
        if (r < 5)       rkey = '0;
        else if (r < 9)  rkey = k(bus.mode ? $urandom_range(0, 9) : $urandom_range(0, 4));
        else             rkey = k($urandom_range(0, 9)) | k($urandom_range(0, 9));
      end
      bus.keypad = rkey;
      bus.sharp  = ($urandom_range(0, 5) == 0);
      bus.star   = ($urandom_range(0, 15) == 0);
      model_step();
      @(posedge clock);
      #1;
      compare($sformatf("rand%0d", c), m_time(), digits.size(), m_cs, m_er, m_valid);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_time_entry.md
Name: keypad_time_entry

Overview:
- Parametrised successor to the fixed three-preset timer-setting FSM. It accepts a time either as direct BCD digit entry or as a preset key, validates it, and hands it to the nap countdown on a `#` confirm.
- Sits between the keypad scanner and the countdown timer.
- Adds the following over the earlier block:
  - N-digit shift-in entry;
  - parameterised presets;
  - `*` clear;
  - press-edge detection;
  - seconds-range validation with an error pulse;
  - a held output value.

Parameters:
- NUM_DIGITS, 3, number of BCD digits, least significant first: one_sec, ten_sec, one_min, ten_min, ...; legal range 2..6.
- PRESET1, 12'h005, packed BCD loaded by key 1 in preset mode (0:05).
- PRESET2, 12'h030, packed BCD loaded by key 2 (0:30).
- PRESET3, 12'h100, packed BCD loaded by key 3 (1:00).
- Presets are 4*NUM_DIGITS wide; higher digits are zero-padded.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  event enable; while 0, key events are ignored and state and outputs hold.
- mode  in  1  0 = preset mode, 1 = direct digit entry; sampled per event.
- sharp  in  1  `#` key level (confirm).
- star  in  1  `*` key level (clear).
- keypad  in  10  one-hot digit key levels; bit d = digit d.
- time_bcd  out  4*NUM_DIGITS  current or confirmed time, packed BCD.
- digit_count  out  $clog2(NUM_DIGITS+1)  digits entered so far.
- completeSetting  out  1  one-cycle pulse on a valid confirm.
- entry_error  out  1  one-cycle pulse on a rejected confirm.
- setting_valid  out  1  level; high from a valid confirm until the next edit or reset.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; time_bcd=0, digit_count=0, completeSetting=0, entry_error=0, setting_valid=0.
  - Edge-detect history is cleared to 0.
- Event detection:
  - Registered previous levels of keypad, sharp and star.
  - A digit event fires when keypad has exactly one bit set and the previous keypad was all-zero. Multi-hot keypad never produces an event.
  - sharp and star events fire on their 0→1 transitions.
  - Events are qualified by en==1. A key held while en rises does not fire.
- Simultaneous events in one cycle, priority highest first: star, then sharp, then digit. Lower-priority events in that cycle are dropped.
- States:
  - IDLE: nothing entered. A digit event goes to ENTRY with the edit applied. sharp goes to ERROR (empty entry).
  - ENTRY:
    - Digit, mode=1: time_bcd <= {time_bcd[4*NUM_DIGITS-5:0], d}; digit_count += 1. Once digit_count==NUM_DIGITS, further digits are ignored (no wrap).
    - Digit, mode=0: keys 1/2/3 load PRESET1/2/3 and set digit_count=NUM_DIGITS. Other digits are ignored.
    - star: time_bcd=0, digit_count=0, go to IDLE.
    - sharp: validate (see below). Pass goes to DONE; fail goes to ERROR.
  - DONE (1 cycle): completeSetting=1, setting_valid<=1, time_bcd held; go to HOLD.
  - HOLD: time_bcd held, setting_valid=1.
    - A digit event clears time_bcd and digit_count, then applies the digit in the same cycle. setting_valid<=0; go to ENTRY.
    - star clears and goes to IDLE with setting_valid<=0.
    - sharp is ignored.
  - ERROR (1 cycle): entry_error=1; time_bcd=0, digit_count=0; go to IDLE.
- Validation passes only when both hold:
  - the ten_sec digit (bits [7:4]) ≤ 5;
  - time_bcd ≠ 0.
  - Digits above ten_sec only need to be ≤ 9, which is always true for keypad input.
- Outputs are registered. An edit is visible on time_bcd one cycle after the event edge. completeSetting asserts one cycle after the sharp edge.
- Reset mid-entry discards everything, with no pulse.
- Unused state encodings return to IDLE.

Decomposition:
- Package keypad_time_pkg holds:
  - the state enum {IDLE, ENTRY, DONE, ERROR, HOLD};
  - BCD_W=4 and MAX_TEN_SEC=4'd5;
  - default preset constants.
- One sub-module, keypad_event_detect: registers levels, produces the one-hot-qualified digit event, decoded digit, sharp_ev and star_ev, and applies en gating and priority.

Test Plan:
1. Reset low for 2 cycles -> all outputs 0, state IDLE; release, then press 5 (mode=1) -> time_bcd=12'h005, digit_count=1.
2. mode=1, press 1, 3, 0, then `#` -> time_bcd=12'h130, completeSetting high exactly 1 cycle, setting_valid=1; a fourth digit before `#` is ignored.
3. mode=1, press 1, 7, 5, then `#` -> entry_error 1-cycle pulse, time_bcd=0, setting_valid=0, no completeSetting.
4. mode=0, press 2 then `#` -> time_bcd=12'h030, completeSetting pulse. Press 7 -> no change. Press 3, then `*` and `#` in the same cycle -> cleared to 0, no pulses.
5. Keys 4 and 6 asserted together, digit held across en 0→1, and `#` with empty entry -> no digit events; `#` alone gives an entry_error pulse.
6. In HOLD at 12'h100, press 9 -> time_bcd=12'h009, setting_valid=0, state ENTRY. Assert reset mid-entry -> everything 0 at the next edge.
